// File: rtl/cab_led_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cab_led_sequencer
// Purpose  : Drives the shared cabinet LED bus (led_data plus three latch
//            strobes) feeding the marquee board (latch 0) and the two LED
//            boards (latches 1, 2). Three requesters post byte writes; a
//            round-robin arbiter grants one at a time and a setup / pulse /
//            hold sequencer presents the byte, strobes the matching latch and
//            holds the byte past the latch falling edge.
// Ports    : clk        - sole clock, rising edge
//            rst_n      - asynchronous active-low reset
//            req[2:0]   - per-channel write request (0 marquee, 1 LED1, 2 LED2)
//            wdata0..2  - per-channel write data, sampled only at grant
//            frame_tick - one-cycle frame pulse (auto-refresh build only)
//            ack[2:0]   - one-cycle completion pulse, first hold cycle
//            busy       - high whenever the sequencer is not idle
//            led_data   - LED bus data, keeps last value while idle
//            led_latch  - active-high latch strobes, at most one bit set
// Options  : `CAB_LED_AUTO_REFRESH_EN builds shadow registers and frame-tick
//            driven refresh of all three boards (no ack, pointer untouched).
// Revision : 1.0 - initial release
// ============================================================================
module cab_led_sequencer #(
   parameter int SETUP_CYC = 2,
   parameter int PULSE_CYC = 4,
   parameter int HOLD_CYC  = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] req,
   input  logic [7:0] wdata0,
   input  logic [7:0] wdata1,
   input  logic [7:0] wdata2,
   input  logic       frame_tick,
   output logic [2:0] ack,
   output logic       busy,
   output logic [7:0] led_data,
   output logic [2:0] led_latch
);

   localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYC - 1);
   localparam logic [3:0] PULSE_LOAD = 4'(PULSE_CYC - 1);
   localparam logic [3:0] HOLD_LOAD  = 4'(HOLD_CYC - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, PULSE = 2'd2, HOLD = 2'd3} state_t;

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [1:0] grant, grant_nxt;
   logic [1:0] ptr, ptr_nxt;
   logic [7:0] data_nxt;
   logic [2:0] latch_nxt;
   logic [2:0] ack_nxt;
   logic       refresh, refresh_nxt;   // current transaction is a refresh
   logic [2:0] grant_onehot;

   // First set request bit at or after the pointer, wrapping modulo 3.
   function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
      int t;
      rr_pick = p;
      // Walk from the farthest candidate back so the nearest one wins.
      for (int j = 2; j >= 0; j--) begin
         t = int'(p) + j;
         if (t >= 3) t = t - 3;
         if (r[t]) rr_pick = 2'(t);
      end
   endfunction

   function automatic logic [7:0] wsel(input logic [1:0] ch, input logic [7:0] d0,
                                       input logic [7:0] d1, input logic [7:0] d2);
      case (ch)
         2'd0:    wsel = d0;
         2'd1:    wsel = d1;
         default: wsel = d2;
      endcase
   endfunction

   assign grant_onehot = 3'b001 << grant;
   assign busy         = (state != IDLE);

`ifdef CAB_LED_AUTO_REFRESH_EN
   logic [7:0] sh [3];
   logic [2:0] pend;
   logic [2:0] pend_clr;
   logic [1:0] pend_low;

   assign pend_low = pend[0] ? 2'd0 : (pend[1] ? 2'd1 : 2'd2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend <= 3'b000;
         for (int i = 0; i < 3; i++) sh[i] <= 8'h00;
      end else begin
         // A tick sets every bit; re-ticks simply re-set what is already set.
         pend <= frame_tick ? 3'b111 : (pend & ~pend_clr);
         if (ack_nxt != 3'b000) sh[grant] <= led_data;
      end
   end
`else
   logic unused_frame_tick;
   assign unused_frame_tick = frame_tick;
`endif

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      grant_nxt   = grant;
      ptr_nxt     = ptr;
      data_nxt    = led_data;
      latch_nxt   = 3'b000;
      ack_nxt     = 3'b000;
      refresh_nxt = refresh;
`ifdef CAB_LED_AUTO_REFRESH_EN
      pend_clr    = 3'b000;
`endif
      case (state)
         IDLE: begin
            if (req != 3'b000) begin
               grant_nxt   = rr_pick(req, ptr);
               ptr_nxt     = (grant_nxt == 2'd2) ? 2'd0 : grant_nxt + 2'd1;
               data_nxt    = wsel(grant_nxt, wdata0, wdata1, wdata2);
               refresh_nxt = 1'b0;
               cnt_nxt     = SETUP_LOAD;
               state_nxt   = SETUP;
`ifdef CAB_LED_AUTO_REFRESH_EN
               pend_clr    = 3'b001 << grant_nxt;
            end else if (pend != 3'b000) begin
               grant_nxt   = pend_low;
               data_nxt    = sh[pend_low];
               refresh_nxt = 1'b1;
               cnt_nxt     = SETUP_LOAD;
               state_nxt   = SETUP;
               pend_clr    = 3'b001 << pend_low;
`endif
            end
         end
         SETUP: begin
            if (cnt == 4'd0) begin
               state_nxt = PULSE;
               cnt_nxt   = PULSE_LOAD;
               latch_nxt = grant_onehot;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         PULSE: begin
            if (cnt == 4'd0) begin
               state_nxt = HOLD;
               cnt_nxt   = HOLD_LOAD;
               ack_nxt   = refresh ? 3'b000 : grant_onehot;
            end else begin
               cnt_nxt   = cnt - 4'd1;
               latch_nxt = grant_onehot;
            end
         end
         HOLD: begin
            if (cnt == 4'd0) state_nxt = IDLE;
            else             cnt_nxt   = cnt - 4'd1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Latch and ack are registered from next-state decode so the strobes
   // leave the block glitch-free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         grant     <= 2'd0;
         ptr       <= 2'd0;
         refresh   <= 1'b0;
         led_data  <= 8'h00;
         led_latch <= 3'b000;
         ack       <= 3'b000;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         grant     <= grant_nxt;
         ptr       <= ptr_nxt;
         refresh   <= refresh_nxt;
         led_data  <= data_nxt;
         led_latch <= latch_nxt;
         ack       <= ack_nxt;
      end
   end

endmodule
`default_nettype wire
